deserializer: RTL

Receive-side counterpart of the team's serial link. Collects serial bits, MSB first, qualified by a valid strobe, into a DATA_W-bit parallel word. Emits a one-cycle valid pulse with the word and its bit count. Supports early termination (flush) of a short word, left-aligned, using the same "0 means full width" length encoding as the transmit side.

---
 rtl/deserializer_if.sv | 41 ++++
 rtl/deserializer.sv | 111 +++++++++++
 2 files changed

// File: rtl/deserializer_if.sv
// deserializer_if: bundles the serial-input and parallel-output signals of the
// deserializer so a source/sink and the block itself share one connection.
//   data_i / data_val_i / flush_i     : serial bit, its qualifier, early-terminate
//   deser_data_o / deser_mod_o        : assembled word (left-aligned) and bit count
//   deser_data_val_o                  : one-cycle word-valid pulse
//   busy_o                            : a partial word is being held
// Modports: master = the side driving serial bits and consuming words,
//           slave  = the deserializer itself.
interface deserializer_if #(
  parameter int DATA_W = 16
);
  localparam int MOD_W = $clog2(DATA_W);

  logic              data_i;
  logic              data_val_i;
  logic              flush_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i,
    output data_val_i,
    output flush_i,
    input  deser_data_o,
    input  deser_mod_o,
    input  deser_data_val_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  data_val_i,
    input  flush_i,
    output deser_data_o,
    output deser_mod_o,
    output deser_data_val_o,
    output busy_o
  );
endinterface

// File: rtl/deserializer.sv
// deserializer: collects MSB-first serial bits into a DATA_W-bit word.
// A full word (DATA_W bits) or a flush of a partial word produces a one-cycle
// pulse on deser_data_val_o together with the left-aligned, zero-filled word
// and its bit count (0 encodes DATA_W). All outputs are registered.
// Ports:
//   clk_i    : clock, rising edge
//   arst_ni  : asynchronous active-low reset
//   bus      : deserializer_if.slave (serial inputs, parallel outputs, busy)
module deserializer #(
  parameter int DATA_W = 16
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  deserializer_if.slave  bus
);
  localparam int MOD_W = $clog2(DATA_W);
  localparam logic [MOD_W-1:0]  CNT_LAST = MOD_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  logic [MOD_W-1:0]  cnt_q,      cnt_d;
  logic [DATA_W-1:0] wrd_q,      wrd_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [MOD_W-1:0]  out_mod_q,  out_mod_d;
  logic              out_val_q,  out_val_d;
  logic              busy_q,     busy_d;

  logic [DATA_W-1:0] bit_mask_s;
  logic [DATA_W-1:0] wrd_base_s;
  logic [DATA_W-1:0] wrd_acc_s;
  logic [MOD_W:0]    eff_cnt_s;
  logic              last_bit_s;

  // Next-state logic: bit insertion, word completion and flush handling.
  always_comb begin
    cnt_d      = cnt_q;
    wrd_d      = wrd_q;
    out_data_d = out_data_q;
    out_mod_d  = out_mod_q;
    out_val_d  = 1'b0;

    // Position of the incoming bit, counted down from the MSB.
    bit_mask_s = MSB_MASK >> cnt_q;

    // Starting a word clears everything, so positions never written stay 0
    // and a flushed word is already zero-filled below its last bit.
    if (cnt_q == {MOD_W{1'b0}}) begin
      wrd_base_s = {DATA_W{1'b0}};
    end else begin
      wrd_base_s = wrd_q;
    end

    if (bus.data_val_i) begin
      wrd_acc_s = (wrd_base_s & ~bit_mask_s) | (bus.data_i ? bit_mask_s : {DATA_W{1'b0}});
    end else begin
      wrd_acc_s = wrd_q;
    end

    // Effective count including this cycle's bit; one bit wider so DATA_W fits.
    eff_cnt_s  = {1'b0, cnt_q} + {{MOD_W{1'b0}}, bus.data_val_i};
    last_bit_s = bus.data_val_i && (cnt_q == CNT_LAST);

    if (bus.data_val_i) begin
      wrd_d = wrd_acc_s;
      cnt_d = cnt_q + MOD_W'(1);
    end else begin
      wrd_d = wrd_q;
      cnt_d = cnt_q;
    end

    // A full word takes priority over a coincident flush: one pulse, mod 0.
    if (last_bit_s) begin
      out_val_d  = 1'b1;
      out_data_d = wrd_acc_s;
      out_mod_d  = {MOD_W{1'b0}};
      cnt_d      = {MOD_W{1'b0}};
    end else if (bus.flush_i && (eff_cnt_s != {(MOD_W+1){1'b0}})) begin
      out_val_d  = 1'b1;
      out_data_d = wrd_acc_s;
      out_mod_d  = eff_cnt_s[MOD_W-1:0];
      cnt_d      = {MOD_W{1'b0}};
    end else begin
      out_val_d  = 1'b0;
    end

    busy_d = (cnt_d != {MOD_W{1'b0}});
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q      <= {MOD_W{1'b0}};
      wrd_q      <= {DATA_W{1'b0}};
      out_data_q <= {DATA_W{1'b0}};
      out_mod_q  <= {MOD_W{1'b0}};
      out_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrd_q      <= wrd_d;
      out_data_q <= out_data_d;
      out_mod_q  <= out_mod_d;
      out_val_q  <= out_val_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.deser_data_o     = out_data_q;
  assign bus.deser_mod_o      = out_mod_q;
  assign bus.deser_data_val_o = out_val_q;
  assign bus.busy_o           = busy_q;
endmodule
